// File: rtl/logic_op_sequencer.sv
// Operand/opcode sequencer for an external 16-bit logic-gate stage.
// Captures A (+opcode), then B for binary ops, latches the gate result and holds it until consumed.
module logic_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [2:0]  opcode,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  output logic [2:0]  op_sel,
  input  logic [15:0] gate_result,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        zero_flag,
  output logic        parity_flag,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {IDLE, LOAD_B, EXEC, DONE} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_valid) state_nxt = (opcode[2:1] == 2'b11) ? EXEC : LOAD_B;
      LOAD_B:  if (data_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    data_ready   = (state == IDLE) || (state == LOAD_B);
    result_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out       <= '0;
      b_out       <= '0;
      op_sel      <= '0;
      result      <= '0;
      zero_flag   <= 1'b0;
      parity_flag <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: if (data_valid) begin
          a_out  <= data_in;
          op_sel <= opcode;
          b_out  <= '0;
        end
        LOAD_B: if (data_valid) b_out <= data_in;
        EXEC: begin
          result      <= gate_result;
          zero_flag   <= (gate_result == 16'h0000);
          parity_flag <= ^gate_result;
        end
        DONE: if (result_ready) op_count <= op_count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
